aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
//  Iterative AES encryption controller. Uses one round of SubBytes/ShiftRows/MixColumns/AddRoundKey
//  and runs it once per clock, instead of the fully unrolled cipher. Round keys come from the existing
//  flat key-schedule bus, in the same layout as Cipher.key_out. Valid/ready handshake on input and output.
//  Sits between the host block interface and the key-expansion logic. Trades latency for area.
// PARAMETERS
//  NUM_RK         13  round keys carried on round_keys (AES-128 uses 11, AES-192 uses 13)
//  CLEAR_ON_DONE  1   1: state register and out_data cleared to 0 after the output handshake
// PORTS
//  clk         in   1           rising-edge clock
//  rst_n       in   1           asynchronous active-low reset
//  in_valid    in   1           plaintext block offered
//  in_ready    out  1           block accepted when in_valid & in_ready
//  in_data     in   128         plaintext, byte 0 in [127:120]
//  size        in   2           00 AES-128 (Nr=10), 01 AES-192 (Nr=12), 1x unsupported
//  round_keys  in   128*NUM_RK  rk[i] = round_keys[128*(NUM_RK-i)-1 -: 128]; rk0 in MSBs
//  out_valid   out  1           ciphertext available
//  out_ready   in   1           downstream accepts when out_valid & out_ready
//  out_data    out  128         ciphertext
//  out_err     out  1           qualified by out_valid; 1 = size was unsupported
//  busy        out  1           high in every state except IDLE
//  round_idx   out  4           current round counter (debug/visibility)
// BEHAVIOUR
//  Reset (asynchronous, active-low):
//   - state=IDLE, state reg=0, rnd=0, Nr reg=0, out_valid=0, out_err=0, out_data=0, busy=0, in_ready=1.
//  FSM states: IDLE, ROUND, FINAL, DONE. in_ready = (state==IDLE); it is not asserted in DONE.
//  IDLE, on accept:
//   - latch size into Nr (10 or 12); st <= in_data ^ rk[0]; rnd <= 1; go ROUND.
//   - if size=1x: st <= 0; out_err <= 1; go DONE directly (1-cycle latency).
//  ROUND:
//   - st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk[rnd]; rnd <= rnd+1.
//   - go FINAL when rnd==Nr-1.
//  FINAL:
//   - st <= ShiftRows(SubBytes(st)) ^ rk[Nr]; go DONE. No MixColumns in this round.
//  DONE:
//   - out_valid=1, out_data=st. Both stay stable until out_ready.
//   - on handshake: go IDLE, out_valid=0, out_err=0; if CLEAR_ON_DONE then st <= 0.
//  Latency:
//   - out_valid rises Nr+1 clocks after the accepting edge: 11 clocks (AES-128), 13 clocks (AES-192).
//   - minimum accept-to-accept interval: Nr+2 clocks.
//  Stability rules:
//   - size is sampled only at accept. A size change mid-operation is ignored.
//   - round_keys is read combinationally each cycle. The key generator must hold it stable from accept
//     until the output handshake. A change during busy corrupts the result and is not flagged.
//  Other rules:
//   - in_valid during busy is ignored (no accept, no queueing).
//   - out_ready while not out_valid has no effect.
//   - round_idx = rnd in ROUND/FINAL, Nr in DONE, 0 in IDLE. The counter never wraps; max value 12.
//   - rst_n low mid-operation: block aborts immediately, all outputs return to reset values, nothing emitted.
//  Byte order and XOR widths match the existing AddRoundKey module: full 128-bit XOR, no truncation.
// TESTING
//  T1 AES-128: pt=00112233445566778899aabbccddeeff, key=000102..0f (schedule from Cipher)
//     -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_err=0, out_valid exactly 11 clk after accept.
//  T2 AES-192: same pt, key=000102..17, size=01
//     -> out_data=dda97ca4864cdfe06eaf70a0ec0d7191, out_valid exactly 13 clk after accept.
//  T3 backpressure: hold out_ready=0 for 20 clk after out_valid
//     -> out_data stable, in_ready=0 throughout, one transfer when out_ready=1, then in_ready=1 next clk.
//  T4 size=2'b10 offered -> out_valid 1 clk after accept, out_data=0, out_err=1; next T1 block passes cleanly.
//  T5 rst_n pulsed low at round 5 of T1 -> out_valid never rises; outputs at reset values; in_ready=1 after release.
//  T6 back-to-back T1 blocks with in_valid, out_ready held high
//     -> 2 correct outputs, accepts 12 clk apart; in_valid during busy is not accepted.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller: one cipher round per clock, round keys taken from a flat
// key-schedule bus (rk0 in the MSBs), valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// ROUND | full rounds 1..Nr-1 (SubBytes, ShiftRows, MixColumns, AddRoundKey)
// FINAL | last round Nr, no MixColumns
// DONE  | result held on out_data until out_ready
module aes_round_sequencer #(
  parameter int NUM_RK        = 13,
  parameter bit CLEAR_ON_DONE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_data,
  input  logic [1:0]            size,
  input  logic [128*NUM_RK-1:0] round_keys,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data,
  output logic                  out_err,
  output logic                  busy,
  output logic [3:0]            round_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

  state_t       state;
  logic [127:0] st;
  logic [3:0]   rnd;
  logic [3:0]   nr;
  logic [127:0] rk [NUM_RK];
  logic [127:0] rk_rnd;
  logic [127:0] rk_nr;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 via an addition chain; 0 maps to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2;
    logic [7:0] a3;
    logic [7:0] a12;
    logic [7:0] t;
    a2  = gf_mul(a, a);
    a3  = gf_mul(a2, a);
    t   = gf_mul(a3, a3);
    a12 = gf_mul(t, t);
    t   = gf_mul(a12, a3);
    for (int i = 0; i < 4; i++) t = gf_mul(t, t);
    return gf_mul(gf_mul(t, a12), a2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  // Byte i = row + 4*col sits at [127-8*i -: 8]; row r rotates left by r columns.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  for (genvar i = 0; i < NUM_RK; i++) begin : g_rk
    assign rk[i] = round_keys[128*(NUM_RK-i)-1 -: 128];
  end

  always_comb begin
    rk_rnd = '0;
    rk_nr  = '0;
    for (int i = 0; i < NUM_RK; i++) begin
      if (rnd == 4'(i)) rk_rnd = rk[i];
      if (nr == 4'(i)) rk_nr = rk[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      st        <= '0;
      rnd       <= '0;
      nr        <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            busy     <= 1'b1;
            in_ready <= 1'b0;
            if (size[1]) begin
              // Unsupported key size: report immediately with an all-zero block.
              st        <= '0;
              nr        <= '0;
              rnd       <= '0;
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              nr    <= size[0] ? 4'd12 : 4'd10;
              st    <= in_data ^ rk[0];
              rnd   <= 4'd1;
              state <= S_ROUND;
            end
          end
        end
        S_ROUND: begin
          st  <= mix_cols(sub_shift(st)) ^ rk_rnd;
          rnd <= rnd + 4'd1;
          if (rnd == nr - 4'd1) state <= S_FINAL;
        end
        S_FINAL: begin
          st        <= sub_shift(st) ^ rk_nr;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            rnd       <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
            if (CLEAR_ON_DONE) st <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_data  = st;
  assign round_idx = rnd;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: accepted blocks are encrypted by a byte-array AES model
// and queued; a monitor checks every output handshake, latency, round index and hold behaviour.
module tb_aes_round_sequencer;
  localparam int NUM_RK = 13;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [127:0]          in_data = '0;
  logic [1:0]            size = '0;
  logic [128*NUM_RK-1:0] round_keys = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [127:0]          out_data;
  logic                  out_err;
  logic                  busy;
  logic [3:0]            round_idx;

  aes_round_sequencer #(.NUM_RK(NUM_RK), .CLEAR_ON_DONE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .size(size), .round_keys(round_keys), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .busy(busy), .round_idx(round_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt,
                                                 input logic [128*NUM_RK-1:0] keys, input int nr);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] k;
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(4*c+r) -: 8];
    for (int rd = 0; rd <= nr; rd++) begin
      if (rd > 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) t[r][c] = sbox_t[s[r][(c+r)%4]];
        for (int c = 0; c < 4; c++) begin
          if (rd < nr) begin
            s[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
            s[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
            s[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
            s[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
          end else begin
            for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
          end
        end
      end
      k = keys[128*(NUM_RK-rd)-1 -: 128];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ k[127-8*(4*c+r) -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  // Standard key expansion; unused trailing round-key slots are filled with noise.
  function automatic logic [128*NUM_RK-1:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]           w [52];
    logic [31:0]           tmp;
    logic [7:0]            rcon;
    logic [128*NUM_RK-1:0] bus;
    for (int i = 0; i < NUM_RK*4; i++) bus[32*i +: 32] = $urandom;
    for (int i = 0; i < 52; i++) w[i] = '0;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]] ^ rcon, sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < nk+7; i++)
      bus[128*(NUM_RK-i)-1 -: 128] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
    return bus;
  endfunction

  // ---------------- scoreboard monitor ----------------
  typedef struct {
    logic [127:0] data;
    logic         err;
    int           nr;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  logic         active = 1'b0;
  bit           rose = 1'b0;
  bit           holding = 1'b0;
  bit           just_done = 1'b0;
  logic [127:0] held = '0;
  logic [127:0] last_out = '0;
  logic         last_err = 1'b0;
  int           out_count = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      active = 1'b0;
      rose = 1'b0;
      holding = 1'b0;
      just_done = 1'b0;
    end else begin
      chk("busy", 128'(busy), 128'(active));
      chk("in_ready", 128'(in_ready), 128'(!active));
      if (just_done) chk("cleared_after_done", out_data, 128'h0);
      just_done = 1'b0;
      if (holding) begin
        chk("hold_valid", 128'(out_valid), 128'h1);
        chk("hold_data", out_data, held);
      end
      holding = 1'b0;
      if (out_valid && !rose) begin
        rose = 1'b1;
        if (sb.size() == 0) fail_now("unexpected out_valid");
        else chk("latency", 128'(cyc - sb[0].acc + 1), 128'(sb[0].err ? 1 : sb[0].nr + 1));
      end
      if (active && sb.size() > 0 && !sb[0].err) begin
        if (!out_valid) chk("round_idx_run", 128'(round_idx), 128'(cyc - sb[0].acc + 1));
        else chk("round_idx_done", 128'(round_idx), 128'(sb[0].nr));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail_now("output with empty scoreboard");
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_err", 128'(out_err), 128'(e.err));
        end
        last_out = out_data;
        last_err = out_err;
        out_count++;
        active = 1'b0;
        rose = 1'b0;
        just_done = 1'b1;
      end else if (out_valid) begin
        holding = 1'b1;
        held = out_data;
      end
      if (in_valid && in_ready) begin
        e.err  = size[1];
        e.nr   = size[1] ? 0 : (size[0] ? 12 : 10);
        e.data = size[1] ? 128'h0 : model_encrypt(in_data, round_keys, e.nr);
        e.acc  = cyc + 1;
        sb.push_back(e);
        active = 1'b1;
      end
    end
  end

  // out_ready: 0 = always high, 1 = random, 2 = held low
  int or_mode = 0;
  always @(posedge clk) begin
    #2;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- driver ----------------
  task automatic send(input logic [127:0] pt, input logic [1:0] sz, input bit keep, output int acc);
    in_data  = pt;
    size     = sz;
    in_valid = 1'b1;
    acc      = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc + 1;
        break;
      end
    end
    if (acc < 0) fail_now("accept timeout");
    @(posedge clk);
    #2;
    if (!keep) in_valid = 1'b0;
    size    = 2'($urandom);
    in_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (!active && sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("idle timeout");
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'h1);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'h0);
    chk({tag, "_out_err"}, 128'(out_err), 128'h0);
    chk({tag, "_out_data"}, out_data, 128'h0);
    chk({tag, "_busy"}, 128'(busy), 128'h0);
    chk({tag, "_round_idx"}, 128'(round_idx), 128'h0);
  endtask

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

  logic [128*NUM_RK-1:0] keys128;
  logic [128*NUM_RK-1:0] keys192;
  int                    a1, a2, cnt0, rsel;
  bit                    ok;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    keys128 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    keys192 = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // T1 / T2 known answers
    round_keys = keys128;
    send(PT, 2'b00, 1'b0, a1);
    wait_idle();
    chk("t1_kat", last_out, CT128);
    round_keys = keys192;
    send(PT, 2'b01, 1'b0, a1);
    wait_idle();
    chk("t2_kat", last_out, CT192);

    // T3 backpressure, with a stray block offered while held
    or_mode = 2;
    round_keys = keys128;
    send(PT, 2'b00, 1'b0, a1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("t3 out_valid timeout");
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    repeat (20) @(posedge clk);
    #2;
    in_valid = 1'b0;
    or_mode  = 0;
    wait_idle();
    chk("t3_kat", last_out, CT128);

    // T4 unsupported size, then a clean block
    send({$urandom, $urandom, $urandom, $urandom}, 2'b10, 1'b0, a1);
    wait_idle();
    chk("t4_err", 128'(last_err), 128'h1);
    chk("t4_data", last_out, 128'h0);
    send(PT, 2'b00, 1'b0, a1);
    wait_idle();
    chk("t4_after_kat", last_out, CT128);

    // T5 reset in the middle of round 5
    send(PT, 2'b00, 1'b0, a1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (round_idx == 4'd5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("t5 round 5 not reached");
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t5_async");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("t5_in_ready", 128'(in_ready), 128'h1);
    chk("t5_no_output", 128'(out_valid), 128'h0);

    // T6 back-to-back with in_valid held high
    cnt0 = out_count;
    round_keys = keys128;
    send(PT, 2'b00, 1'b1, a1);
    send(PT, 2'b00, 1'b0, a2);
    wait_idle();
    chk("t6_interval", 128'(a2 - a1), 128'd12);
    chk("t6_outputs", 128'(out_count - cnt0), 128'd2);
    chk("t6_kat", last_out, CT128);

    // randomized blocks with random backpressure
    or_mode = 1;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NUM_RK*4; i++) round_keys[32*i +: 32] = $urandom;
      rsel = $urandom_range(0, 9);
      send({$urandom, $urandom, $urandom, $urandom},
           (rsel < 1) ? 2'(2 + $urandom_range(0, 1)) : ((rsel < 5) ? 2'b00 : 2'b01), 1'b0, a1);
      wait_idle();
    end
    or_mode = 0;
    wait_idle();
    chk("final_queue_empty", 128'(sb.size()), 128'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
